// File: rtl/sysid_arb_pkg.sv
// Shared types and constants for the system-ID access arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sysid_arb_pkg;

  localparam int   COUNT_W = 16;
  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    ST_CHK_ID = 3'd0,
    ST_CHK_TS = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACCESS = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant from req, remembers the last winner.
// Latency: grant is combinational; last_grant updates on the advance edge.
// Backpressure: grant only moves on advance, so a stalled winner keeps its grant.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       last_grant
);

  logic last_grant_q;
  logic last_grant_d;

  // A lone requester always wins; on a tie the side that did not win last time wins.
  always_comb begin
    grant[0] = req[0] & (~req[1] | last_grant_q);
    grant[1] = req[1] & (~req[0] | ~last_grant_q);
  end

  // Record the winner only when the grant is actually consumed.
  always_comb begin
    last_grant_d = last_grant_q;
    if (advance) begin
      last_grant_d = grant[1];
    end
  end

  // Reset to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant = last_grant_q;

endmodule

// File: rtl/sysid_access_arbiter.sv
// Boot-checks the sysid slave, then shares it round-robin between two pipelined-read masters.
// Latency: accept in cycle N, readdatavalid in cycle N+2; one read every 3 cycles.
// Backpressure: waitrequest held high outside IDLE or when the other side is granted; nothing dropped.
module sysid_access_arbiter
  import sysid_arb_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS = 32'h0000_0000,
  parameter bit          CHECK_EN    = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               r0_read,
  input  logic               r0_address,
  output logic               r0_waitrequest,
  output logic [31:0]        r0_readdata,
  output logic               r0_readdatavalid,
  input  logic               r1_read,
  input  logic               r1_address,
  output logic               r1_waitrequest,
  output logic [31:0]        r1_readdata,
  output logic               r1_readdatavalid,
  output logic               s_address,
  output logic               s_read,
  input  logic [31:0]        s_readdata,
  output logic               check_done,
  output logic               id_ok,
  output logic               ts_ok,
  output logic [COUNT_W-1:0] access_count
);

  state_e             state_q, state_d;
  logic               s_address_q, s_address_d;
  logic               s_read_q, s_read_d;
  logic [31:0]        rdata0_q, rdata0_d;
  logic [31:0]        rdata1_q, rdata1_d;
  logic               check_done_q, check_done_d;
  logic               id_ok_q, id_ok_d;
  logic               ts_ok_q, ts_ok_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic [1:0] grant;
  logic       owner;    // arbiter's last winner doubles as the in-flight requester id
  logic       idle;
  logic       advance;
  logic       resp;

  // Reset overrides IDLE so no request is accepted while the block is being reset.
  assign idle    = (state_q == ST_IDLE) & ~reset;
  assign advance = idle & (r0_read | r1_read);
  assign resp    = (state_q == ST_RESP) & ~reset;

  rr_arbiter2 u_arb (
    .clock      (clock),
    .reset      (reset),
    .req        ({r1_read, r0_read}),
    .advance    (advance),
    .grant      (grant),
    .last_grant (owner)
  );

  // Next-state logic: boot check, then IDLE -> ACCESS -> RESP service loop.
  always_comb begin
    state_d      = state_q;
    s_address_d  = s_address_q;
    s_read_d     = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    check_done_d = check_done_q;
    id_ok_d      = id_ok_q;
    ts_ok_d      = ts_ok_q;
    count_d      = count_q;
    if (!CHECK_EN) begin
      check_done_d = 1'b1;
    end
    case (state_q)
      ST_CHK_ID: begin
        id_ok_d     = (s_readdata == EXPECTED_ID);
        s_address_d = ADDR_TS;
        s_read_d    = 1'b1;
        state_d     = ST_CHK_TS;
      end
      ST_CHK_TS: begin
        ts_ok_d      = (s_readdata == EXPECTED_TS);
        check_done_d = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_IDLE: begin
        if (advance) begin
          s_address_d = grant[1] ? r1_address : r0_address;
          s_read_d    = 1'b1;
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (owner) begin
          rdata1_d = s_readdata;
        end else begin
          rdata0_d = s_readdata;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (count_q != {COUNT_W{1'b1}}) begin
          count_d = count_q + COUNT_W'(1);
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight read and reruns the check.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= CHECK_EN ? ST_CHK_ID : ST_IDLE;
      s_address_q  <= ADDR_ID;
      s_read_q     <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      check_done_q <= 1'b0;
      id_ok_q      <= 1'b0;
      ts_ok_q      <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      s_address_q  <= s_address_d;
      s_read_q     <= s_read_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      check_done_q <= check_done_d;
      id_ok_q      <= id_ok_d;
      ts_ok_q      <= ts_ok_d;
      count_q      <= count_d;
    end
  end

  assign r0_waitrequest   = r0_read & ~(idle & grant[0]);
  assign r1_waitrequest   = r1_read & ~(idle & grant[1]);
  assign r0_readdatavalid = resp & ~owner;
  assign r1_readdatavalid = resp & owner;
  assign r0_readdata      = rdata0_q;
  assign r1_readdata      = rdata1_q;
  assign s_address        = s_address_q;
  assign s_read           = s_read_q;
  assign check_done       = check_done_q;
  assign id_ok            = id_ok_q;
  assign ts_ok            = ts_ok_q;
  assign access_count     = count_q;

endmodule

// File: tb/tb_sysid_access_arbiter.sv
// Self-checking bench for sysid_access_arbiter: directed scenarios plus a randomized run.
// Latency: n/a.
// Backpressure: requesters hold read until waitrequest is low.
module tb_sysid_access_arbiter;

  localparam logic [31:0] EXP_ID = 32'h1234_5678;
  localparam logic [31:0] EXP_TS = 32'h5EED_0001;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        r0_read = 1'b0, r0_address = 1'b0;
  logic        r1_read = 1'b0, r1_address = 1'b0;
  logic        r0_waitrequest, r0_readdatavalid, r1_waitrequest, r1_readdatavalid;
  logic [31:0] r0_readdata, r1_readdata, s_readdata;
  logic        s_address, s_read, check_done, id_ok, ts_ok;
  logic [15:0] access_count;
  logic [31:0] word0 = EXP_ID;
  logic [31:0] word1 = EXP_TS;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  // Combinational sysid slave model.
  assign s_readdata = s_address ? word1 : word0;

  sysid_access_arbiter #(
    .EXPECTED_ID (EXP_ID),
    .EXPECTED_TS (EXP_TS),
    .CHECK_EN    (1'b1)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .r0_read          (r0_read),
    .r0_address       (r0_address),
    .r0_waitrequest   (r0_waitrequest),
    .r0_readdata      (r0_readdata),
    .r0_readdatavalid (r0_readdatavalid),
    .r1_read          (r1_read),
    .r1_address       (r1_address),
    .r1_waitrequest   (r1_waitrequest),
    .r1_readdata      (r1_readdata),
    .r1_readdatavalid (r1_readdatavalid),
    .s_address        (s_address),
    .s_read           (s_read),
    .s_readdata       (s_readdata),
    .check_done       (check_done),
    .id_ok            (id_ok),
    .ts_ok            (ts_ok),
    .access_count     (access_count)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Leaves the bench 1 time unit into the first cycle after release (CHK_ID).
  task automatic do_reset();
    @(posedge clock);
    #1;
    reset   = 1'b1;
    r0_read = 1'b0;
    r1_read = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    word0 = EXP_ID;
    word1 = EXP_TS;
    @(posedge clock);
    #1;
    reset = 1'b1;
    r0_read = 1'b1;
    r1_read = 1'b0;
    @(posedge clock);
    #1;
    n_checks++;
    if ({r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid, s_read, s_address,
         check_done, id_ok, ts_ok} !== 9'b100000000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 100000000", {r0_waitrequest, r1_waitrequest,
               r0_readdatavalid, r1_readdatavalid, s_read, s_address, check_done, id_ok, ts_ok});
    end
    n_checks++;
    if ({r0_readdata, r1_readdata, access_count} !== 80'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h expected zeros", r0_readdata, r1_readdata, access_count);
    end
    r0_read = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({s_address, check_done} !== 2'b00) begin
      n_fail++;
      $display("FAIL boot_cycle1: got addr=%b done=%b expected addr=0 done=0", s_address, check_done);
    end
    step();
    n_checks++;
    if ({s_address, s_read, check_done} !== 3'b110) begin
      n_fail++;
      $display("FAIL boot_cycle2: got addr=%b read=%b done=%b expected 1 1 0", s_address, s_read, check_done);
    end
    step();
    n_checks++;
    if ({check_done, id_ok, ts_ok, s_read} !== 4'b1110) begin
      n_fail++;
      $display("FAIL boot_cycle3: got done=%b id=%b ts=%b read=%b expected 1 1 1 0",
               check_done, id_ok, ts_ok, s_read);
    end
  endtask

  // Runs from the first IDLE cycle left by test_reset.
  task automatic test_single();
    r0_address = 1'b1;
    r0_read    = 1'b1;
    #1;
    n_checks++;
    if (r0_waitrequest !== 1'b0) begin
      n_fail++;
      $display("FAIL single_accept: got waitrequest=%b expected 0", r0_waitrequest);
    end
    step();
    r0_read = 1'b0;
    #1;
    n_checks++;
    if ({r0_readdatavalid, s_read, s_address} !== 3'b011) begin
      n_fail++;
      $display("FAIL single_access: got valid=%b read=%b addr=%b expected 0 1 1",
               r0_readdatavalid, s_read, s_address);
    end
    step();
    n_checks++;
    if ({r0_readdatavalid, r1_readdatavalid, s_read} !== 3'b100 || r0_readdata !== EXP_TS) begin
      n_fail++;
      $display("FAIL single_resp: got v0=%b v1=%b read=%b data=%h expected 1 0 0 %h",
               r0_readdatavalid, r1_readdatavalid, s_read, r0_readdata, EXP_TS);
    end
    step();
    n_checks++;
    if (r0_readdatavalid !== 1'b0 || access_count !== 16'd1 || r0_readdata !== EXP_TS) begin
      n_fail++;
      $display("FAIL single_after: got valid=%b count=%0d data=%h expected 0 1 %h",
               r0_readdatavalid, access_count, r0_readdata, EXP_TS);
    end
  endtask

  task automatic test_boot_mismatch();
    word1 = 32'hDEAD_BEEF;
    do_reset();
    step();
    step();
    n_checks++;
    if ({check_done, id_ok, ts_ok} !== 3'b110 || access_count !== 16'd0) begin
      n_fail++;
      $display("FAIL boot_mismatch: got done=%b id=%b ts=%b count=%0d expected 1 1 0 0",
               check_done, id_ok, ts_ok, access_count);
    end
    word1 = EXP_TS;
  endtask

  task automatic test_request_during_check();
    do_reset();
    r1_address = 1'b0;
    r1_read    = 1'b1;
    #1;
    n_checks++;
    if (r1_waitrequest !== 1'b1) begin
      n_fail++;
      $display("FAIL chk_wait_id: got %b expected 1", r1_waitrequest);
    end
    step();
    n_checks++;
    if (r1_waitrequest !== 1'b1) begin
      n_fail++;
      $display("FAIL chk_wait_ts: got %b expected 1", r1_waitrequest);
    end
    step();
    n_checks++;
    if (r1_waitrequest !== 1'b0) begin
      n_fail++;
      $display("FAIL chk_first_idle: got %b expected 0", r1_waitrequest);
    end
    step();
    r1_read = 1'b0;
    step();
    n_checks++;
    if ({r1_readdatavalid, r0_readdatavalid} !== 2'b10 || r1_readdata !== EXP_ID) begin
      n_fail++;
      $display("FAIL chk_resp: got v1=%b v0=%b data=%h expected 1 0 %h",
               r1_readdatavalid, r0_readdatavalid, r1_readdata, EXP_ID);
    end
  endtask

  task automatic test_round_robin();
    int pulses;
    int exp_side;
    do_reset();
    step();
    step();
    r0_address = 1'b0;
    r1_address = 1'b1;
    r0_read    = 1'b1;
    r1_read    = 1'b1;
    pulses     = 0;
    for (int c = 0; c < 40 && pulses < 6; c++) begin
      #1;
      n_checks++;
      if (r0_waitrequest === 1'b0 && r1_waitrequest === 1'b0) begin
        n_fail++;
        $display("FAIL rr_double_accept: got both waitrequest low expected at most one");
      end
      if (r0_readdatavalid === 1'b1 || r1_readdatavalid === 1'b1) begin
        exp_side = pulses % 2;
        n_checks++;
        if ({r1_readdatavalid, r0_readdatavalid} !== ((exp_side == 1) ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL rr_order: pulse %0d got v1v0=%b%b expected side %0d",
                   pulses, r1_readdatavalid, r0_readdatavalid, exp_side);
        end
        n_checks++;
        if ((exp_side == 1 ? r1_readdata : r0_readdata) !== (exp_side == 1 ? EXP_TS : EXP_ID)) begin
          n_fail++;
          $display("FAIL rr_data: pulse %0d got %h expected %h", pulses,
                   (exp_side == 1 ? r1_readdata : r0_readdata), (exp_side == 1 ? EXP_TS : EXP_ID));
        end
        pulses++;
      end
      if (pulses < 6) step();
    end
    r0_read = 1'b0;
    r1_read = 1'b0;
    n_checks++;
    if (pulses != 6) begin
      n_fail++;
      $display("FAIL rr_timeout: got %0d pulses expected 6", pulses);
    end
    step();
    n_checks++;
    if (access_count !== 16'd6) begin
      n_fail++;
      $display("FAIL rr_count: got %0d expected 6", access_count);
    end
  endtask

  // Starts in IDLE with a non-zero access count left by the previous test.
  task automatic test_reset_mid();
    r0_address = 1'b0;
    r0_read    = 1'b1;
    #1;
    n_checks++;
    if (r0_waitrequest !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_accept: got %b expected 0", r0_waitrequest);
    end
    step();
    r0_read = 1'b0;
    reset   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (r0_readdatavalid !== 1'b0 || r1_readdatavalid !== 1'b0 || access_count !== 16'd0 ||
          {check_done, id_ok, ts_ok} !== 3'b000 || r0_readdata !== 32'd0) begin
        n_fail++;
        $display("FAIL mid_reset_%0d: got v0=%b v1=%b count=%0d flags=%b data=%h expected all zero",
                 i, r0_readdatavalid, r1_readdatavalid, access_count,
                 {check_done, id_ok, ts_ok}, r0_readdata);
      end
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (s_address !== 1'b0 || check_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_chk_id: got addr=%b done=%b expected 0 0", s_address, check_done);
    end
    step();
    n_checks++;
    if (s_address !== 1'b1 || r0_readdatavalid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_chk_ts: got addr=%b valid=%b expected 1 0", s_address, r0_readdatavalid);
    end
    step();
    n_checks++;
    if ({check_done, id_ok, ts_ok, r0_readdatavalid} !== 4'b1110) begin
      n_fail++;
      $display("FAIL mid_recheck: got %b expected 1110", {check_done, id_ok, ts_ok, r0_readdatavalid});
    end
  endtask

  // Model: the slave serves one read per 3 cycles; a pending request is taken as soon as the
  // slave is free, ties go to whoever did not win last, data appears 2 cycles after acceptance.
  task automatic test_random();
    logic        rd [2];
    logic        ad [2];
    logic        acc_prev [2];
    logic [31:0] last_dat [2];
    int          ev_cyc [$];
    int          ev_who [$];
    logic [31:0] ev_dat [$];
    int          next_free, last, who, cnt, acc_cyc, vside;
    logic        acc_addr;
    logic [1:0]  exp_v;

    do_reset();
    step();
    step();
    word0 = $urandom;
    word1 = $urandom;
    rd = '{1'b0, 1'b0};
    ad = '{1'b0, 1'b0};
    acc_prev = '{1'b0, 1'b0};
    last_dat = '{32'd0, 32'd0};
    next_free = 0;
    last = 1;
    cnt = 0;
    acc_cyc = -10;
    acc_addr = 1'b0;

    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (acc_prev[n]) rd[n] = 1'b0;
        else if (!rd[n]) begin
          if (c < 390 && $urandom_range(0, 2) == 0) begin
            rd[n] = 1'b1;
            ad[n] = 1'($urandom_range(0, 1));
          end
        end else if ($urandom_range(0, 3) == 0) ad[n] = 1'($urandom_range(0, 1));
      end
      r0_read = rd[0]; r0_address = ad[0];
      r1_read = rd[1]; r1_address = ad[1];
      #1;

      who = -1;
      if (c >= next_free && (rd[0] || rd[1])) begin
        if (rd[0] && rd[1]) who = (last == 0) ? 1 : 0;
        else who = rd[0] ? 0 : 1;
      end

      n_checks++;
      if ({r1_waitrequest, r0_waitrequest} !== {rd[1] && who != 1, rd[0] && who != 0}) begin
        n_fail++;
        $display("FAIL rand_wait c=%0d: got %b%b expected %b%b", c, r1_waitrequest, r0_waitrequest,
                 rd[1] && who != 1, rd[0] && who != 0);
      end

      exp_v = 2'b00;
      if (ev_cyc.size() > 0 && ev_cyc[0] == c) begin
        vside = ev_who[0];
        exp_v = (vside == 1) ? 2'b10 : 2'b01;
        last_dat[vside] = ev_dat[0];
        void'(ev_cyc.pop_front());
        void'(ev_who.pop_front());
        void'(ev_dat.pop_front());
      end
      n_checks++;
      if ({r1_readdatavalid, r0_readdatavalid} !== exp_v) begin
        n_fail++;
        $display("FAIL rand_valid c=%0d: got %b%b expected %b", c, r1_readdatavalid, r0_readdatavalid, exp_v);
      end
      n_checks++;
      if (r0_readdata !== last_dat[0] || r1_readdata !== last_dat[1]) begin
        n_fail++;
        $display("FAIL rand_data c=%0d: got %h %h expected %h %h", c, r0_readdata, r1_readdata,
                 last_dat[0], last_dat[1]);
      end
      n_checks++;
      if (access_count !== 16'(cnt)) begin
        n_fail++;
        $display("FAIL rand_count c=%0d: got %0d expected %0d", c, access_count, cnt);
      end
      if (exp_v != 2'b00) cnt++;
      n_checks++;
      if (s_read !== (c == acc_cyc + 1) || (c == acc_cyc + 1 && s_address !== acc_addr)) begin
        n_fail++;
        $display("FAIL rand_slave c=%0d: got read=%b addr=%b expected read=%b addr=%b", c, s_read,
                 s_address, (c == acc_cyc + 1), acc_addr);
      end

      acc_prev = '{1'b0, 1'b0};
      if (who >= 0) begin
        acc_prev[who] = 1'b1;
        last = who;
        next_free = c + 3;
        acc_cyc = c;
        acc_addr = ad[who];
        ev_cyc.push_back(c + 2);
        ev_who.push_back(who);
        ev_dat.push_back(ad[who] ? word1 : word0);
      end
      step();
    end
    r0_read = 1'b0;
    r1_read = 1'b0;
    n_checks++;
    if (ev_cyc.size() != 0 || cnt == 0) begin
      n_fail++;
      $display("FAIL rand_drain: got %0d pending, %0d serviced expected 0 pending, >0 serviced",
               ev_cyc.size(), cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_boot_mismatch();
    test_request_during_check();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
